sram_2p_gbuf: RTL and testbench

//  Parametrised 1-read/1-write global-buffer SRAM, next generation of the systolic-array buffer.

---
 rtl/sram_2p_gbuf.sv | 145 ++++++++++++++
 tb/tb_sram_2p_gbuf.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_2p_gbuf.sv
// Global-buffer SRAM, one read and one write port, byte-enable writes,
// write-first forwarding, 1- or 2-cycle read latency and a sequential clear engine.
module sram_2p_gbuf #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_data_valid,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_cnt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              rd_fire;
    logic              wr_fire;
    logic              rd_in_range;
    logic              wr_in_range;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] rd_word;

    assign rd_ready    = ~clr_busy;
    assign wr_ready    = ~clr_busy;
    assign rd_fire     = rd_valid & rd_ready;
    assign wr_fire     = wr_valid & wr_ready;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_V;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_V;

    // Next state of the clear/run controller.
    always_comb begin
        state_d  = state_q;
        clr_busy = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_busy = 1'b1;
                if (clr_cnt == LAST) state_d = RUN;
            end
            RUN: begin
                if (clr_req) state_d = CLEAR;
            end
            default: state_d = CLEAR;
        endcase
    end

    // Controller state and clear address counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR && clr_cnt != LAST) clr_cnt <= clr_cnt + 1'b1;
            else                                     clr_cnt <= '0;
        end
    end

    // Old word with the enabled write bytes merged in.
    always_comb begin
        wr_merged = '0;
        if (wr_in_range) wr_merged = mem[wr_addr];
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    // Read word, write-first on a same-address collision, zero when out of range.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
            if (wr_fire && wr_in_range && wr_addr == rd_addr) rd_word = wr_merged;
        end
    end

    // Array update: clear engine owns the port while busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_busy)                    mem[clr_cnt] <= '0;
            else if (wr_fire && wr_in_range) mem[wr_addr] <= wr_merged;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_valid;
            logic [DATA_W-1:0] s1_data;

            // First read stage: capture the addressed word.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                end else begin
                    s1_valid <= rd_fire;
                    if (rd_fire) s1_data <= rd_word;
                end
            end

            // Output stage: data holds while no read is returning.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_valid <= 1'b0;
                    rd_data       <= '0;
                end else begin
                    rd_data_valid <= s1_valid;
                    if (s1_valid) rd_data <= s1_data;
                end
            end
        end else begin : g_lat1
            // Single read stage: data holds while no read is returning.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_valid <= 1'b0;
                    rd_data       <= '0;
                end else begin
                    rd_data_valid <= rd_fire;
                    if (rd_fire) rd_data <= rd_word;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sram_2p_gbuf.sv
// Directed bench for sram_2p_gbuf: a 256-deep RD_LAT=1 instance
// and a 200-deep RD_LAT=2 instance, checked against hand-computed values.
module tb_sram_2p_gbuf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: DEPTH 256, RD_LAT 1
    logic         rst, clr_req, clr_busy;
    logic         rd_valid, rd_ready, rd_data_valid;
    logic [7:0]   rd_addr;
    logic [127:0] rd_data;
    logic         wr_valid, wr_ready;
    logic [7:0]   wr_addr;
    logic [15:0]  wr_be;
    logic [127:0] wr_data;

    // Instance B: DEPTH 200, RD_LAT 2
    logic         b_rst, b_clr_req, b_clr_busy;
    logic         b_rd_valid, b_rd_ready, b_rd_data_valid;
    logic [7:0]   b_rd_addr;
    logic [127:0] b_rd_data;
    logic         b_wr_valid, b_wr_ready;
    logic [7:0]   b_wr_addr;
    logic [15:0]  b_wr_be;
    logic [127:0] b_wr_data;

    sram_2p_gbuf #(.DATA_W(128), .DEPTH(256), .ADDR_W(8), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(clr_busy),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data)
    );

    sram_2p_gbuf #(.DATA_W(128), .DEPTH(200), .ADDR_W(8), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(b_rst), .clr_req(b_clr_req), .clr_busy(b_clr_busy),
        .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_data_valid(b_rd_data_valid),
        .wr_valid(b_wr_valid), .wr_ready(b_wr_ready), .wr_addr(b_wr_addr),
        .wr_be(b_wr_be), .wr_data(b_wr_data)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int  n;
    bit  strobe;
    logic [127:0] v10, v11;

    initial begin
        rst = 1'b1; clr_req = 0; rd_valid = 0; rd_addr = 0;
        wr_valid = 0; wr_addr = 0; wr_be = 0; wr_data = 0;
        b_rst = 1'b1; b_clr_req = 0; b_rd_valid = 0; b_rd_addr = 0;
        b_wr_valid = 0; b_wr_addr = 0; b_wr_be = 0; b_wr_data = 0;

        // 1: reset state and clear length
        @(negedge clk);
        chk("rst_rdv", 128'(rd_data_valid), 128'd0);
        chk("rst_rdd", rd_data, 128'd0);
        chk("rst_busy", 128'(clr_busy), 128'd1);
        chk("rst_rdy", 128'(rd_ready), 128'd0);
        rst = 1'b0;
        n = 0;
        while (clr_busy && n < 1000) begin n++; @(negedge clk); end
        chk("clr_len", 128'(n), 128'd256);
        chk("run_wrdy", 128'(wr_ready), 128'd1);
        n = 0;
        for (int a = 0; a < 256; a++) begin
            rd_valid = 1'b1; rd_addr = 8'(a);
            @(negedge clk);
            if (rd_data_valid !== 1'b1 || rd_data !== 128'd0) n++;
        end
        rd_valid = 1'b0;
        chk("all_zero_bad_cnt", 128'(n), 128'd0);

        // 2: full write then read
        wr_valid = 1; wr_addr = 5; wr_be = 16'hFFFF; wr_data = {16{8'hA5}};
        @(negedge clk);
        chk("wr_no_strobe", 128'(rd_data_valid), 128'd0);
        wr_valid = 0; rd_valid = 1; rd_addr = 5;
        @(negedge clk);
        rd_valid = 0;
        chk("rd5_v", 128'(rd_data_valid), 128'd1);
        chk("rd5_d", rd_data, {16{8'hA5}});
        @(negedge clk);
        chk("rd5_v_drop", 128'(rd_data_valid), 128'd0);
        chk("rd5_hold", rd_data, {16{8'hA5}});

        // 3: read-during-write with partial byte enables
        wr_valid = 1; wr_addr = 7; wr_be = 16'h00F0; wr_data = {16{8'hFF}};
        rd_valid = 1; rd_addr = 7;
        @(negedge clk);
        chk("rdw_d", rd_data, 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000);
        chk("rdw_v", 128'(rd_data_valid), 128'd1);
        wr_addr = 7; wr_be = 16'h0001; wr_data = {16{8'h11}};
        rd_valid = 0;
        @(negedge clk);
        wr_be = 16'h0000; wr_data = {16{8'h22}};
        @(negedge clk);
        wr_valid = 0; rd_valid = 1; rd_addr = 7;
        @(negedge clk);
        rd_valid = 0;
        chk("be_merge", rd_data, 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0011);

        // 4: clear request with a same-cycle write
        for (int a = 0; a < 4; a++) begin
            wr_valid = 1; wr_addr = 8'(a); wr_be = 16'hFFFF;
            wr_data = {16{8'(8'h10 + a)}};
            @(negedge clk);
        end
        rd_valid = 1; rd_addr = 2; wr_valid = 0;
        @(negedge clk);
        chk("fill2", rd_data, {16{8'h12}});
        wr_valid = 1; wr_addr = 9; wr_be = 16'hFFFF; wr_data = {16{8'h99}};
        clr_req = 1; rd_valid = 1; rd_addr = 9;
        @(negedge clk);
        chk("clr_wr_fwd", rd_data, {16{8'h99}});
        chk("clr_busy_on", 128'(clr_busy), 128'd1);
        clr_req = 0; wr_valid = 0; rd_valid = 1; rd_addr = 0;
        @(negedge clk);
        chk("busy_rdy", 128'(rd_ready), 128'd0);
        chk("busy_nostrobe", 128'(rd_data_valid), 128'd0);
        n = 1; strobe = 0;
        while (clr_busy && n < 1000) begin
            if (rd_data_valid) strobe = 1;
            n++;
            @(negedge clk);
        end
        rd_valid = 0;
        chk("clr2_len", 128'(n), 128'd256);
        chk("clr2_strobe", 128'(strobe), 128'd0);
        n = 0;
        for (int a = 0; a < 5; a++) begin
            rd_valid = 1; rd_addr = (a == 4) ? 8'd9 : 8'(a);
            @(negedge clk);
            if (rd_data_valid !== 1'b1 || rd_data !== 128'd0) n++;
        end
        rd_valid = 0;
        chk("cleared_bad_cnt", 128'(n), 128'd0);

        // Instance B: clear length for DEPTH 200
        b_rst = 0;
        n = 0;
        while (b_clr_busy && n < 1000) begin n++; @(negedge clk); end
        chk("b_clr_len", 128'(n), 128'd200);

        // RD_LAT 2 back-to-back reads
        v10 = {4{32'hDEAD_0010}};
        v11 = {4{32'hBEEF_0011}};
        b_wr_valid = 1; b_wr_be = 16'hFFFF; b_wr_addr = 10; b_wr_data = v10;
        @(negedge clk);
        b_wr_addr = 11; b_wr_data = v11;
        @(negedge clk);
        b_wr_valid = 0; b_rd_valid = 1; b_rd_addr = 10;
        @(negedge clk);
        chk("b_lat_v0", 128'(b_rd_data_valid), 128'd0);
        b_rd_addr = 11;
        @(negedge clk);
        b_rd_valid = 0;
        chk("b_rd10_v", 128'(b_rd_data_valid), 128'd1);
        chk("b_rd10_d", b_rd_data, v10);
        @(negedge clk);
        chk("b_rd11_v", 128'(b_rd_data_valid), 128'd1);
        chk("b_rd11_d", b_rd_data, v11);
        @(negedge clk);
        chk("b_drop_v", 128'(b_rd_data_valid), 128'd0);
        chk("b_hold", b_rd_data, v11);

        // 5: out-of-range write dropped, read returns 0 with strobe
        b_wr_valid = 1; b_wr_addr = 210; b_wr_data = {16{8'h5A}};
        @(negedge clk);
        b_wr_valid = 0; b_rd_valid = 1; b_rd_addr = 210;
        @(negedge clk);
        b_rd_addr = 10;
        @(negedge clk);
        b_rd_addr = 199;
        chk("b_oor_v", 128'(b_rd_data_valid), 128'd1);
        chk("b_oor_d", b_rd_data, 128'd0);
        @(negedge clk);
        b_rd_valid = 0;
        chk("b_keep10", b_rd_data, v10);
        @(negedge clk);
        chk("b_rd199", b_rd_data, 128'd0);

        // 6: reset drops a pending read, then reset mid-clear restarts it
        b_rd_valid = 1; b_rd_addr = 11;
        @(negedge clk);
        b_rd_valid = 0; b_rst = 1;
        @(negedge clk);
        chk("b_rst_pend_v", 128'(b_rd_data_valid), 128'd0);
        chk("b_rst_d", b_rd_data, 128'd0);
        b_rst = 0;
        @(negedge clk);
        chk("b_rst_pend_v2", 128'(b_rd_data_valid), 128'd0);
        repeat (99) @(negedge clk);
        chk("b_mid_busy", 128'(b_clr_busy), 128'd1);
        b_rst = 1;
        @(negedge clk);
        b_rst = 0;
        n = 0;
        while (b_clr_busy && n < 1000) begin n++; @(negedge clk); end
        chk("b_restart_len", 128'(n), 128'd200);
        b_rd_valid = 1; b_rd_addr = 10;
        @(negedge clk);
        b_rd_valid = 0;
        @(negedge clk);
        chk("b_cleared10", b_rd_data, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
